// File: rtl/dlatch_bank_sync.sv
// Clocked stand-in for an enable latch bank with local clear, plus a FIFO that
// records the value held each time the transparent window closes.
module dlatch_bank_sync #(
    parameter int unsigned       WIDTH   = 8,
    parameter bit                EN_POL  = 1'b1,
    parameter bit                CLR_POL = 1'b1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0,
    parameter logic [WIDTH-1:0]  CLR_VAL = '1,
    parameter int unsigned       DEPTH   = 4
) (
    input  logic                         C,
    input  logic                         R,
    input  logic                         E,
    input  logic                         CLR,
    input  logic [WIDTH-1:0]             D,
    output logic [WIDTH-1:0]             Q,
    output logic                         OPEN,
    output logic                         H_VALID,
    output logic [WIDTH-1:0]             H_DATA,
    input  logic                         H_POP,
    output logic [$clog2(DEPTH+1)-1:0]   H_COUNT,
    output logic                         H_OVF
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_q;
    logic             r_open;
    logic             r_ovf;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_e_act;
    logic             w_c_act;
    logic             w_close;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_ovf_set;
    logic [CNT_W-1:0] w_count_nxt;

    // Control decode; a close is an open window ending without a clear.
    always_comb begin
        w_e_act   = (E == EN_POL);
        w_c_act   = (CLR == CLR_POL);
        w_close   = r_open && !w_e_act && !w_c_act && !R;
        w_full    = (r_count == CNT_W'(DEPTH));
        w_pop     = H_POP && (r_count != '0) && !R;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        w_push    = w_close && (!w_full || w_pop);
        w_ovf_set = w_close && w_full && !w_pop;
    end

    // Occupancy next-state.
    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Latch value, window flag, FIFO pointers and sticky overflow.
    always_ff @(posedge C) begin
        if (R) begin
            r_q      <= RST_VAL;
            r_open   <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_c_act) begin
                r_q    <= CLR_VAL;
                r_open <= 1'b0;
            end else if (w_e_act) begin
                r_q    <= D;
                r_open <= 1'b1;
            end else begin
                r_open <= 1'b0;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_nxt;
            if (w_ovf_set) r_ovf <= 1'b1;
        end
    end

    // History storage; when full with a pop, the slot written is the head being popped.
    always_ff @(posedge C) begin
        if (w_push) r_mem[r_wr_ptr] <= r_q;
    end

    assign Q       = r_q;
    assign OPEN    = r_open;
    assign H_VALID = (r_count != '0);
    assign H_DATA  = r_mem[r_rd_ptr];
    assign H_COUNT = r_count;
    assign H_OVF   = r_ovf;

endmodule

// File: tb/tb_dlatch_bank_sync.sv
// Directed checks for dlatch_bank_sync: default-polarity bank plus an inverted-polarity instance.
module tb_dlatch_bank_sync;

    logic       C = 1'b0;
    always #5 C = ~C;

    logic       R, E, CLR, H_POP;
    logic [7:0] D;
    logic [7:0] Q, H_DATA;
    logic       OPEN, H_VALID, H_OVF;
    logic [2:0] H_COUNT;

    logic       p_R, p_E, p_CLR, p_POP;
    logic [7:0] p_D;
    logic [7:0] p_Q, p_HD;
    logic       p_OPEN, p_HV, p_OVF;
    logic [2:0] p_CNT;

    int n_pass = 0;
    int n_total = 0;

    dlatch_bank_sync #(
        .WIDTH(8), .EN_POL(1'b1), .CLR_POL(1'b1),
        .RST_VAL(8'h00), .CLR_VAL(8'hFF), .DEPTH(4)
    ) u_dut (
        .C(C), .R(R), .E(E), .CLR(CLR), .D(D), .Q(Q), .OPEN(OPEN),
        .H_VALID(H_VALID), .H_DATA(H_DATA), .H_POP(H_POP),
        .H_COUNT(H_COUNT), .H_OVF(H_OVF)
    );

    dlatch_bank_sync #(
        .WIDTH(8), .EN_POL(1'b0), .CLR_POL(1'b0),
        .RST_VAL(8'hFF), .CLR_VAL(8'hFF), .DEPTH(4)
    ) u_pol (
        .C(C), .R(p_R), .E(p_E), .CLR(p_CLR), .D(p_D), .Q(p_Q), .OPEN(p_OPEN),
        .H_VALID(p_HV), .H_DATA(p_HD), .H_POP(p_POP),
        .H_COUNT(p_CNT), .H_OVF(p_OVF)
    );

    task automatic step();
        @(posedge C);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic window(input logic [7:0] v);
        E = 1'b1; D = v; step();
        E = 1'b0;        step();
    endtask

    initial begin
        R = 1'b1; E = 1'b0; CLR = 1'b0; D = 8'h00; H_POP = 1'b0;
        p_R = 1'b1; p_E = 1'b1; p_CLR = 1'b1; p_D = 8'h00; p_POP = 1'b0;
        step();
        chk("rst_q",     32'(Q), 32'h00);
        chk("rst_open",  32'(OPEN), 32'h0);
        chk("rst_valid", 32'(H_VALID), 32'h0);
        chk("rst_count", 32'(H_COUNT), 32'h0);
        chk("rst_ovf",   32'(H_OVF), 32'h0);
        R = 1'b0;

        // Basic window
        E = 1'b1; D = 8'h3C; step();
        chk("win_q0", 32'(Q), 32'h3C);
        chk("win_open0", 32'(OPEN), 32'h1);
        D = 8'h5A; step();
        chk("win_q1", 32'(Q), 32'h5A);
        chk("win_cnt_open", 32'(H_COUNT), 32'h0);
        E = 1'b0; D = 8'h77; step();
        chk("close_q", 32'(Q), 32'h5A);
        chk("close_open", 32'(OPEN), 32'h0);
        chk("close_cnt", 32'(H_COUNT), 32'h1);
        chk("close_hdata", 32'(H_DATA), 32'h5A);
        step();
        chk("hold_q", 32'(Q), 32'h5A);
        chk("hold_cnt", 32'(H_COUNT), 32'h1);
        H_POP = 1'b1; step();
        chk("pop_cnt", 32'(H_COUNT), 32'h0);
        chk("pop_valid", 32'(H_VALID), 32'h0);
        step();
        chk("pop_empty_ign", 32'(H_COUNT), 32'h0);
        H_POP = 1'b0;

        // Clear beats enable and closes without a push
        E = 1'b1; D = 8'h11; step(); step();
        chk("clr_pre_q", 32'(Q), 32'h11);
        CLR = 1'b1; step();
        chk("clr_q", 32'(Q), 32'hFF);
        chk("clr_open", 32'(OPEN), 32'h0);
        chk("clr_cnt", 32'(H_COUNT), 32'h0);
        CLR = 1'b0; E = 1'b0; step();
        chk("clr_nopush", 32'(H_COUNT), 32'h0);
        chk("clr_hold_q", 32'(Q), 32'hFF);

        // Overflow
        for (int v = 1; v <= 4; v++) window(8'(v));
        chk("full_cnt", 32'(H_COUNT), 32'h4);
        chk("full_ovf0", 32'(H_OVF), 32'h0);
        window(8'h05);
        chk("ovf_cnt", 32'(H_COUNT), 32'h4);
        chk("ovf_flag", 32'(H_OVF), 32'h1);
        for (int v = 1; v <= 4; v++) begin
            chk("ovf_head", 32'(H_DATA), 32'(v));
            H_POP = 1'b1; step(); H_POP = 1'b0;
        end
        chk("drain_valid", 32'(H_VALID), 32'h0);
        chk("ovf_sticky", 32'(H_OVF), 32'h1);

        // Full FIFO with close and pop in the same cycle
        R = 1'b1; step(); R = 1'b0;
        chk("rst2_ovf", 32'(H_OVF), 32'h0);
        for (int v = 0; v < 4; v++) window(8'(8'h10 + v));
        chk("f2_cnt", 32'(H_COUNT), 32'h4);
        E = 1'b1; D = 8'h20; step();
        E = 1'b0; H_POP = 1'b1; step();
        chk("simul_cnt", 32'(H_COUNT), 32'h4);
        chk("simul_ovf", 32'(H_OVF), 32'h0);
        chk("simul_head", 32'(H_DATA), 32'h11);
        step(); chk("simul_h12", 32'(H_DATA), 32'h12);
        step(); chk("simul_h13", 32'(H_DATA), 32'h13);
        step(); chk("simul_tail", 32'(H_DATA), 32'h20);
        chk("simul_cnt1", 32'(H_COUNT), 32'h1);
        H_POP = 1'b0;

        // Reset mid-operation
        window(8'h30); window(8'h31);
        chk("mid_cnt3", 32'(H_COUNT), 32'h3);
        E = 1'b1; D = 8'hA5; step();
        chk("mid_q", 32'(Q), 32'hA5);
        R = 1'b1; step();
        chk("mr_q", 32'(Q), 32'h00);
        chk("mr_open", 32'(OPEN), 32'h0);
        chk("mr_cnt", 32'(H_COUNT), 32'h0);
        chk("mr_valid", 32'(H_VALID), 32'h0);
        chk("mr_ovf", 32'(H_OVF), 32'h0);
        R = 1'b0; E = 1'b0; step();
        chk("mr_nopush", 32'(H_COUNT), 32'h0);

        // Close with pop while empty: pop ignored, push lands
        E = 1'b1; D = 8'h66; step();
        E = 1'b0; H_POP = 1'b1; step();
        H_POP = 1'b0;
        chk("empty_simul_cnt", 32'(H_COUNT), 32'h1);
        chk("empty_simul_data", 32'(H_DATA), 32'h66);

        // Inverted polarity instance
        chk("pol_rst_q", 32'(p_Q), 32'hFF);
        chk("pol_rst_cnt", 32'(p_CNT), 32'h0);
        p_R = 1'b0; p_E = 1'b0; p_D = 8'h42; step();
        chk("pol_q", 32'(p_Q), 32'h42);
        chk("pol_open", 32'(p_OPEN), 32'h1);
        p_E = 1'b1; p_D = 8'h99; step();
        chk("pol_cnt", 32'(p_CNT), 32'h1);
        chk("pol_hdata", 32'(p_HD), 32'h42);
        chk("pol_hold_q", 32'(p_Q), 32'h42);
        p_CLR = 1'b0; step();
        chk("pol_clr_q", 32'(p_Q), 32'hFF);
        chk("pol_clr_open", 32'(p_OPEN), 32'h0);
        chk("pol_clr_cnt", 32'(p_CNT), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
